// File: rtl/hh_spike_if.sv
// hh_spike_if: membrane-voltage stream in, spike/peak/rate results out.
interface hh_spike_if #(parameter int CNT_W = 8);
  logic [15:0] v_in;
  logic v_valid;
  logic spike;
  logic in_refrac;
  logic [15:0] peak_v;
  logic peak_valid;
  logic [CNT_W-1:0] spike_count;
  logic count_valid;
  modport master(output v_in, v_valid, input spike, in_refrac, peak_v, peak_valid, spike_count, count_valid);
  modport slave(input v_in, v_valid, output spike, in_refrac, peak_v, peak_valid, spike_count, count_valid);
endinterface

// File: rtl/hh_spike_detect.sv
// hh_spike_detect: threshold/hysteresis spike detector with refractory hold-off, peak capture and windowed rate count.
module hh_spike_detect #(
  parameter logic signed [15:0] THRESH = 16'sh0000,
  parameter logic [15:0] HYST = 16'h0500,
  parameter int REFRAC = 8,
  parameter int WIN = 1024,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  hh_spike_if.slave io_bus
);
  localparam int RW = $clog2(REFRAC + 2);
  localparam int WW = $clog2(WIN);
  typedef enum logic [1:0] {S_WAIT_LOW, S_ARMED, S_ABOVE, S_REFRAC} state_t;
  state_t r_state;
  logic signed [15:0] r_peak, r_peak_v;
  logic [RW-1:0] r_cnt;
  logic r_spike, r_in_refrac, r_peak_valid, r_count_valid;
  logic [WW-1:0] r_wc;
  logic [CNT_W-1:0] r_acc, r_count;
  logic signed [15:0] w_v;
  logic signed [16:0] w_low;
  logic w_below, w_above, w_wrap;
  logic [CNT_W-1:0] w_acc;
  assign w_v = io_bus.v_in;
  // 17-bit re-arm level so THRESH - HYST cannot wrap
  assign w_low = $signed({THRESH[15], THRESH}) - $signed({1'b0, HYST});
  assign w_below = $signed({w_v[15], w_v}) < w_low;
  assign w_above = w_v >= THRESH;
  assign w_wrap = r_wc == WW'(WIN - 1);
  assign w_acc = (r_spike && r_acc != '1) ? r_acc + 1'b1 : r_acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_WAIT_LOW;
      r_peak <= '0;
      r_peak_v <= '0;
      r_cnt <= '0;
      r_spike <= 1'b0;
      r_in_refrac <= 1'b0;
      r_peak_valid <= 1'b0;
    end else begin
      r_spike <= 1'b0;
      r_peak_valid <= 1'b0;
      case (r_state)
        S_WAIT_LOW: if (io_bus.v_valid && w_below) r_state <= S_ARMED;
        S_ARMED: if (io_bus.v_valid && w_above) begin
          r_state <= S_ABOVE;
          r_spike <= 1'b1;
          r_peak <= w_v;
        end
        S_ABOVE: if (io_bus.v_valid) begin
          r_peak <= (w_v > r_peak) ? w_v : r_peak;
          if (!w_above) begin
            r_peak_v <= r_peak;
            r_peak_valid <= 1'b1;
            r_cnt <= RW'(REFRAC == 0 ? 0 : REFRAC - 1);
            r_in_refrac <= REFRAC != 0;
            r_state <= (REFRAC == 0) ? S_WAIT_LOW : S_REFRAC;
          end
        end
        S_REFRAC: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= S_WAIT_LOW;
            r_in_refrac <= 1'b0;
          end
        end
        default: r_state <= S_WAIT_LOW;
      endcase
    end
  // a spike output on the wrap cycle is folded into the closing window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wc <= '0;
      r_acc <= '0;
      r_count <= '0;
      r_count_valid <= 1'b0;
    end else begin
      r_wc <= w_wrap ? '0 : r_wc + 1'b1;
      r_acc <= w_wrap ? '0 : w_acc;
      r_count_valid <= w_wrap;
      if (w_wrap) r_count <= w_acc;
    end
  assign io_bus.spike = r_spike;
  assign io_bus.in_refrac = r_in_refrac;
  assign io_bus.peak_v = r_peak_v;
  assign io_bus.peak_valid = r_peak_valid;
  assign io_bus.spike_count = r_count;
  assign io_bus.count_valid = r_count_valid;
endmodule

// File: tb/tb_hh_spike_detect.sv
// tb_hh_spike_detect: two configurations (REFRAC=8/WIN=16 and REFRAC=0/WIN=4096) against a behavioural model.
module tb_hh_spike_detect;
  localparam int LOW = 0 - 1280;
  logic clk, rst;
  logic [15:0] v_in;
  logic v_valid;
  int n_chk, n_pass, ncyc;
  int refr[2], win[2];
  bit armed[2], above[2], e_spike[2], e_refrac[2], e_pv[2], e_cv[2];
  int left[2], pk[2], wc[2], acc[2], e_peak[2], e_cnt[2];
  hh_spike_if #(.CNT_W(8)) bus_a ();
  hh_spike_if #(.CNT_W(8)) bus_b ();
  assign bus_a.v_in = v_in;
  assign bus_a.v_valid = v_valid;
  assign bus_b.v_in = v_in;
  assign bus_b.v_valid = v_valid;
  hh_spike_detect #(.REFRAC(8), .WIN(16), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .io_bus(bus_a));
  hh_spike_detect #(.REFRAC(0), .WIN(4096), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .io_bus(bus_b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
  endtask
  function automatic int sat(input int x);
    return x > 255 ? 255 : x;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      armed[k] = 0; above[k] = 0; e_spike[k] = 0; e_refrac[k] = 0; e_pv[k] = 0; e_cv[k] = 0;
      left[k] = 0; pk[k] = 0; wc[k] = 0; acc[k] = 0; e_peak[k] = 0; e_cnt[k] = 0;
    end
  endtask
  task automatic model_step(input int k);
    int v;
    v = int'($signed(v_in));
    if (wc[k] == win[k] - 1) begin
      e_cnt[k] = sat(acc[k] + int'(e_spike[k]));
      e_cv[k] = 1;
      acc[k] = 0;
    end else begin
      acc[k] = sat(acc[k] + int'(e_spike[k]));
      e_cv[k] = 0;
    end
    wc[k] = (wc[k] + 1) % win[k];
    e_spike[k] = 0;
    e_pv[k] = 0;
    if (left[k] > 0) left[k]--;
    else if (above[k]) begin
      if (v_valid) begin
        if (v > pk[k]) pk[k] = v;
        if (v < 0) begin
          above[k] = 0; e_peak[k] = pk[k]; e_pv[k] = 1; left[k] = refr[k];
        end
      end
    end else if (!armed[k]) armed[k] = v_valid && v < LOW;
    else if (v_valid && v >= 0) begin
      armed[k] = 0; above[k] = 1; e_spike[k] = 1; pk[k] = v;
    end
    e_refrac[k] = left[k] > 0;
  endtask
  task automatic cmp_all();
    chk("spike_a", bus_a.spike, e_spike[0]);
    chk("refrac_a", bus_a.in_refrac, e_refrac[0]);
    chk("peak_a", bus_a.peak_v, e_peak[0] & 'hFFFF);
    chk("pvalid_a", bus_a.peak_valid, e_pv[0]);
    chk("count_a", bus_a.spike_count, e_cnt[0]);
    chk("cvalid_a", bus_a.count_valid, e_cv[0]);
    chk("spike_b", bus_b.spike, e_spike[1]);
    chk("refrac_b", bus_b.in_refrac, e_refrac[1]);
    chk("peak_b", bus_b.peak_v, e_peak[1] & 'hFFFF);
    chk("pvalid_b", bus_b.peak_valid, e_pv[1]);
    chk("count_b", bus_b.spike_count, e_cnt[1]);
    chk("cvalid_b", bus_b.count_valid, e_cv[1]);
  endtask
  task automatic step(input logic [15:0] v, input logic vv);
    v_in = v;
    v_valid = vv;
    @(posedge clk);
    model_step(0);
    model_step(1);
    ncyc++;
    @(negedge clk);
    cmp_all();
  endtask
  function automatic logic [15:0] rand_v();
    case ($urandom_range(0, 3))
      0: return 16'(32'hDF80 + $urandom_range(0, 255));
      1: return 16'(int'($urandom_range(0, 2000)) - 1000);
      2: return 16'($urandom_range(0, 16'h3000));
      default: return 16'($urandom);
    endcase
  endfunction
  initial begin
    refr[0] = 8; win[0] = 16; refr[1] = 0; win[1] = 4096;
    n_chk = 0; n_pass = 0; ncyc = 0;
    rst = 1'b1; v_in = '0; v_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    cmp_all();
    rst = 1'b0;
    step(16'h0A00, 1'b1);
    chk("unarmed_no_spike", bus_a.spike, 1'b0);
    step(16'hDF80, 1'b1);
    step(16'h0A00, 1'b1);
    chk("single_spike", bus_a.spike, 1'b1);
    step(16'h1400, 1'b1);
    chk("spike_one_cycle", bus_a.spike, 1'b0);
    step(16'h0500, 1'b1);
    step(16'hFB80, 1'b1);
    chk("peak_value", bus_a.peak_v, 16'h1400);
    chk("peak_valid", bus_a.peak_valid, 1'b1);
    chk("refrac_rise", bus_a.in_refrac, 1'b1);
    repeat (7) step(16'hDF80, 1'b0);
    chk("refrac_hold", bus_a.in_refrac, 1'b1);
    step(16'hDF80, 1'b0);
    chk("refrac_drop", bus_a.in_refrac, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(i[0] ? 16'h0280 : 16'hFD80, 1'b1);
      chk("hyst_no_spike", bus_a.spike, 1'b0);
    end
    step(16'hFA00, 1'b1);
    step(16'h0280, 1'b1);
    chk("rearm_spike", bus_a.spike, 1'b1);
    step(16'hFB80, 1'b1);
    repeat (8) step(16'hFA00, 1'b1);
    step(16'hFA00, 1'b1);
    step(16'h0A00, 1'b0);
    chk("gated_no_spike", bus_a.spike, 1'b0);
    step(16'h0A00, 1'b1);
    chk("gated_then_spike", bus_a.spike, 1'b1);
    step(16'hFB80, 1'b1);
    step(16'h0000, 1'b0);
    step(16'h0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_refrac", bus_a.in_refrac, 1'b0);
    chk("arst_peak", bus_a.peak_v, 16'h0000);
    chk("arst_count", bus_a.spike_count, 8'h00);
    chk("arst_peak_b", bus_b.peak_v, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    ncyc = 0;
    step(16'h0A00, 1'b1);
    chk("post_reset_no_spike", bus_a.spike, 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(16'hDF80, 1'b1);
      step(16'h0A00, 1'b1);
      step(16'hDF80, 1'b1);
    end
    while (ncyc < 4096) step(rand_v(), $urandom_range(0, 3) != 0);
    chk("sat_count_valid", bus_b.count_valid, 1'b1);
    chk("sat_count", bus_b.spike_count, 8'd255);
    repeat (100) step(rand_v(), $urandom_range(0, 3) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
